spw_timecode_sched: RTL and testbench

- Avalon-MM slave that schedules SpaceWire time-code transmission and drives the codec's tick_in/time_in pair.
- Acts as time master: it either sends on CPU command (one-shot) or periodically from a programmable cycle counter.
- It auto-increments the 6-bit time value mod 64.
- Sits beside the CPU PIO peripherals, between the Avalon interconnect and the SpaceWire codec transmit time-code input.

---
 rtl/spw_tc_pkg.sv | 20 ++
 rtl/spw_timecode_sched_if.sv | 11 +
 rtl/spw_tc_period_timer.sv | 24 ++
 rtl/spw_timecode_sched.sv | 142 ++++++++++++++
 tb/tb_spw_timecode_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spw_tc_pkg.sv
// Shared constants for the SpaceWire time-code scheduler: register map,
// CTRL/STATUS bit positions and the transmit FSM state encoding.
package spw_tc_pkg;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_TIME   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_AUTO_EN = 0;
  localparam int CTRL_SEND    = 1;
  localparam int CTRL_INC_EN  = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int ST_BUSY     = 0;
  localparam int ST_OVERRUN  = 1;
  localparam int ST_CNT_LSB  = 8;
  localparam int ST_IRQ_PEND = 16;

  typedef enum logic [1:0] {IDLE, WAIT, TICK, GUARD} tc_state_e;
endpackage

// File: rtl/spw_timecode_sched_if.sv
// Avalon-MM register bus between the interconnect and the time-code scheduler.
interface spw_timecode_sched_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/spw_tc_period_timer.sv
// Free-running period down-counter: fires one expiry pulse every PERIOD cycles
// while enabled; PERIOD=0 disables it. reload re-arms it to PERIOD-1.
module spw_tc_period_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         reload,
  input  logic [W-1:0] period,
  output logic         expire
);
  logic [W-1:0] cnt;
  logic         run;

  assign run    = en && (period != '0);
  assign expire = run && (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (reload) cnt <= period - W'(1);
    else if (run)    cnt <= (cnt == '0) ? period - W'(1) : cnt - W'(1);
  end
endmodule

// File: rtl/spw_timecode_sched.sv
// SpaceWire time-code master: manual or periodic tick_in/time_in generation
// with auto-increment. Optional tick interrupt under SPW_TICK_IRQ_EN.
module spw_timecode_sched
  import spw_tc_pkg::*;
#(
  parameter int PERIOD_W  = 24,
  parameter int GUARD_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spw_timecode_sched_if.slave  bus,
  input  logic                 tx_ready,
  output logic                 tick_in,
  output logic [7:0]           time_in
`ifdef SPW_TICK_IRQ_EN
  ,output logic                irq
`endif
);
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);

  tc_state_e         state;
  logic [GW-1:0]     gcnt;
  logic              auto_en, inc_en, overrun;
  logic [PERIOD_W-1:0] period;
  logic [7:0]        time_reg, tick_cnt;
  logic              wr, wr_ctrl, wr_period, wr_time, wr_status;
  logic              send, expire, req, busy, tmr_reload;
  logic [31:0]       rdata;
`ifdef SPW_TICK_IRQ_EN
  logic              irq_en, irq_pend;
`endif

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
  assign wr_period = wr && (bus.address == ADDR_PERIOD);
  assign wr_time   = wr && (bus.address == ADDR_TIME);
  assign wr_status = wr && (bus.address == ADDR_STATUS);

  assign send       = wr_ctrl & bus.writedata[CTRL_SEND];
  assign tmr_reload = wr_ctrl & auto_en & ~bus.writedata[CTRL_AUTO_EN];
  assign req        = send | expire;
  assign busy       = (state != IDLE);

  spw_tc_period_timer #(.W(PERIOD_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (auto_en),
    .reload (tmr_reload),
    .period (period),
    .expire (expire)
  );

  // time_in is latched on entry to TICK so a same-cycle TIME write cannot disturb it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gcnt    <= '0;
      tick_in <= 1'b0;
      time_in <= 8'h00;
    end else begin
      case (state)
        IDLE:  if (req) state <= WAIT;
        WAIT:  if (tx_ready) begin
                 state   <= TICK;
                 tick_in <= 1'b1;
                 time_in <= time_reg;
               end
        TICK:  begin
                 state   <= GUARD;
                 tick_in <= 1'b0;
                 gcnt    <= GUARD_LOAD;
               end
        GUARD: if (gcnt == '0) state <= IDLE;
               else            gcnt  <= gcnt - GW'(1);
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_en  <= 1'b0;
      inc_en   <= 1'b0;
      period   <= '0;
      time_reg <= 8'h00;
      overrun  <= 1'b0;
      tick_cnt <= 8'h00;
    end else begin
      if (wr_ctrl) begin
        auto_en <= bus.writedata[CTRL_AUTO_EN];
        inc_en  <= bus.writedata[CTRL_INC_EN];
      end
      if (wr_period) period <= bus.writedata[PERIOD_W-1:0];
      // CPU write beats the post-tick increment
      if (wr_time)                        time_reg      <= bus.writedata[7:0];
      else if (state == TICK && inc_en)   time_reg[5:0] <= time_reg[5:0] + 6'd1;
      if (req && busy)                                     overrun <= 1'b1;
      else if (wr_status && bus.writedata[ST_OVERRUN])     overrun <= 1'b0;
      if (wr_status)    tick_cnt <= 8'h00;
      else if (tick_in) tick_cnt <= tick_cnt + 8'd1;
    end
  end

`ifdef SPW_TICK_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= bus.writedata[CTRL_IRQ_EN];
      if (tick_in)                                       irq_pend <= 1'b1;
      else if (wr_status && bus.writedata[ST_IRQ_PEND])  irq_pend <= 1'b0;
    end
  end
  assign irq = irq_pend & irq_en;
`endif

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        rdata[CTRL_AUTO_EN] = auto_en;
        rdata[CTRL_INC_EN]  = inc_en;
`ifdef SPW_TICK_IRQ_EN
        rdata[CTRL_IRQ_EN]  = irq_en;
`endif
      end
      ADDR_PERIOD: rdata[PERIOD_W-1:0] = period;
      ADDR_TIME:   rdata[7:0]          = time_reg;
      default: begin
        rdata[ST_BUSY]                 = busy;
        rdata[ST_OVERRUN]              = overrun;
        rdata[ST_CNT_LSB +: 8]         = tick_cnt;
`ifdef SPW_TICK_IRQ_EN
        rdata[ST_IRQ_PEND]             = irq_pend;
`endif
      end
    endcase
  end
  assign bus.readdata = rdata;
endmodule

// File: tb/tb_spw_timecode_sched.sv
// Self-checking bench for spw_timecode_sched: register table, directed
// corner sequences and a randomized send stream against a request/guard model.
module tb_spw_timecode_sched;
  import spw_tc_pkg::*;
  localparam int GUARD_CYC = 4;

  logic       clk = 1'b0, reset_n = 1'b0, tx_ready = 1'b0;
  logic       tick_in;
  logic [7:0] time_in;
`ifdef SPW_TICK_IRQ_EN
  logic       irq;
`endif
  int npass = 0, ntot = 0;

  spw_timecode_sched_if bus();

  spw_timecode_sched #(.PERIOD_W(24), .GUARD_CYC(GUARD_CYC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .tx_ready(tx_ready),
    .tick_in (tick_in),
    .time_in (time_in)
`ifdef SPW_TICK_IRQ_EN
    ,.irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle_bus();
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;
  endtask

  // called at a negedge; the write is taken on the following posedge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp,
                        input logic [31:0] mask);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    chk(nm, bus.readdata & mask, exp & mask);
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_tick(input string nm, input int max, output logic [7:0] tv);
    tv = 8'hxx;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tick_in) begin tv = time_in; return; end
    end
    ntot++;
    $display("FAIL %s: no tick_in within %0d cycles", nm, max);
  endtask

  task automatic count_ticks(input int n, inout int cnt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick_in) cnt++;
    end
  endtask

  initial begin
    vec_t       vt[8];
    logic [7:0] tv;
    logic [31:0] ctrl_all;
    int         cnt;
    logic [7:0] mtime, tv0;
    logic [7:0] exp_q[$];
    int         free_at, m_ticks;
    logic       m_ovr;

    idle_bus();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_tick_in", {31'b0, tick_in}, 32'd0);
    chk("rst_time_in", {24'b0, time_in}, 32'd0);
    for (int a = 0; a < 4; a++) rd_chk($sformatf("rst_rd%0d", a), 2'(a), 32'd0, 32'hFFFF_FFFF);

`ifdef SPW_TICK_IRQ_EN
    ctrl_all = 32'hC;
`else
    ctrl_all = 32'h4;
`endif
    vt[0] = '{ADDR_PERIOD, 32'h00AB_CDEF, 32'h00AB_CDEF};
    vt[1] = '{ADDR_PERIOD, 32'hFF12_3456, 32'h0012_3456};
    vt[2] = '{ADDR_PERIOD, 32'h0000_0000, 32'h0000_0000};
    vt[3] = '{ADDR_TIME,   32'hFFFF_FF5A, 32'h0000_005A};
    vt[4] = '{ADDR_TIME,   32'h0000_0000, 32'h0000_0000};
    vt[5] = '{ADDR_CTRL,   32'hFFFF_FFFC, ctrl_all};
    vt[6] = '{ADDR_CTRL,   32'h0000_0000, 32'h0000_0000};
    vt[7] = '{ADDR_STATUS, 32'hFFFF_FFFF, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      wr(vt[i].addr, vt[i].wdata);
      rd_chk($sformatf("tbl%0d", i), vt[i].addr, vt[i].exp, 32'hFFFF_FFFF);
    end

    // manual send: latency, one-cycle pulse, increment, tick_cnt
    tx_ready = 1'b1;
    wr(ADDR_TIME, 32'h05);
    wr(ADDR_CTRL, 32'h6);
    chk("lat_n1", {31'b0, tick_in}, 32'd0);
    @(negedge clk);
    chk("lat_n2", {31'b0, tick_in}, 32'd1);
    chk("send_time", {24'b0, time_in}, 32'h05);
    @(negedge clk);
    chk("pulse_1cyc", {31'b0, tick_in}, 32'd0);
    repeat (6) @(negedge clk);
    rd_chk("time_inc", ADDR_TIME, 32'h06, 32'hFF);
    rd_chk("tick_cnt1", ADDR_STATUS, 32'h0000_0100, 32'h0000_FF03);

    // wrap 63->0 with flags kept
    wr(ADDR_TIME, 32'hBF);
    wr(ADDR_CTRL, 32'h6);
    wait_tick("wrap_a", 20, tv);
    chk("wrap_a_time", {24'b0, tv}, 32'hBF);
    repeat (8) @(negedge clk);
    wr(ADDR_CTRL, 32'h6);
    wait_tick("wrap_b", 20, tv);
    chk("wrap_b_time", {24'b0, tv}, 32'h80);
    repeat (6) @(negedge clk);
    rd_chk("wrap_time", ADDR_TIME, 32'h81, 32'hFF);
    rd_chk("wrap_ovr", ADDR_STATUS, 32'h0, 32'h2);

    // periodic mode, PERIOD=10
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    wr(ADDR_PERIOD, 32'd10);
    wr(ADDR_CTRL, 32'h5);
    cnt = 0;
    count_ticks(99, cnt);
    wr(ADDR_CTRL, 32'h4);
    if (tick_in) cnt++;
    rd_chk("per_status", ADDR_STATUS, 32'h0000_0A00, 32'h0000_FF03);
    count_ticks(20, cnt);
    chk("per_ticks", cnt, 32'd10);

    // tx_ready low: stuck in WAIT, further reqs overrun
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    tx_ready = 1'b0;
    wr(ADDR_CTRL, 32'h1);
    cnt = 0;
    count_ticks(35, cnt);
    chk("stall_ticks", cnt, 32'd0);
    rd_chk("stall_status", ADDR_STATUS, 32'h3, 32'h3);
    wr(ADDR_CTRL, 32'h0);
    tx_ready = 1'b1;
    count_ticks(20, cnt);
    chk("stall_release", cnt, 32'd1);
    wr(ADDR_STATUS, 32'h2);
    rd_chk("ovr_clear", ADDR_STATUS, 32'h0, 32'h3);

    // TIME write in the TICK cycle wins over increment
    wr(ADDR_TIME, 32'h10);
    wr(ADDR_CTRL, 32'h6);
    wait_tick("coll", 20, tv);
    wr(ADDR_TIME, 32'h20);
    chk("coll_time_in", {24'b0, tv}, 32'h10);
    rd_chk("coll_time", ADDR_TIME, 32'h20, 32'hFF);
    repeat (8) @(negedge clk);

`ifdef SPW_TICK_IRQ_EN
    wr(ADDR_STATUS, 32'h1_0000);
    wr(ADDR_CTRL, 32'hE);
    chk("irq_pre", {31'b0, irq}, 32'd0);
    wait_tick("irq_tick", 20, tv);
    @(negedge clk);
    chk("irq_set", {31'b0, irq}, 32'd1);
    wr(ADDR_STATUS, 32'h1_0000);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    wr(ADDR_CTRL, 32'h0);
    repeat (8) @(negedge clk);
`endif

    // randomized manual sends vs request/guard acceptance model
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    wr(ADDR_CTRL, 32'h4);
    tv0 = 8'($urandom);
    wr(ADDR_TIME, {24'b0, tv0});
    mtime = tv0; free_at = 0; m_ticks = 0; m_ovr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (tick_in) begin
        if (exp_q.size() == 0) begin
          ntot++;
          $display("FAIL rnd_spurious: tick_in with time_in 0x%0h, none expected", time_in);
        end else chk($sformatf("rnd_tick%0d", c), {24'b0, time_in}, {24'b0, exp_q.pop_front()});
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.address = ADDR_CTRL; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h6;
        if (c >= free_at) begin
          exp_q.push_back(mtime);
          mtime[5:0] = mtime[5:0] + 6'd1;
          free_at = c + 3 + GUARD_CYC;
          m_ticks++;
        end else m_ovr = 1'b1;
      end else idle_bus();
      @(negedge clk);
    end
    idle_bus();
    for (int c = 0; c < 15; c++) begin
      if (tick_in && exp_q.size() != 0)
        chk("rnd_drain", {24'b0, time_in}, {24'b0, exp_q.pop_front()});
      @(negedge clk);
    end
    chk("rnd_q_empty", exp_q.size(), 32'd0);
    rd_chk("rnd_status", ADDR_STATUS, {16'b0, 8'(m_ticks), 6'b0, m_ovr, 1'b0}, 32'h0000_FF03);
    rd_chk("rnd_time", ADDR_TIME, {24'b0, mtime}, 32'hFF);

    // async reset in the middle of a tick
    wr(ADDR_PERIOD, 32'd10);
    wr(ADDR_CTRL, 32'h5);
    wait_tick("rst_mid", 30, tv);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_tick", {31'b0, tick_in}, 32'd0);
    chk("rst_mid_time", {24'b0, time_in}, 32'd0);
    rd_chk("rst_mid_ctrl", ADDR_CTRL, 32'd0, 32'hFFFF_FFFF);
    rd_chk("rst_mid_period", ADDR_PERIOD, 32'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    reset_n = 1'b1;
    count_ticks(20, cnt);
    rd_chk("rst_mid_status", ADDR_STATUS, 32'd0, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
